nw_fill_sequencer: RTL and testbench
====================================

Name: nw_fill_sequencer

Overview:
- Sequences filling of the Needleman-Wunsch score matrix, cell by cell, in row-major order from (1,1) to (LEN_A,LEN_B).
- For each cell it:
  - issues the three neighbour reads (diag, up, left) to the score memory;
  - pulses operand-load strobes to the cell calculator;
  - starts the calculation and waits for its done handshake;
  - writes the result back.
- Sits between the top-level control FSM (start / end_filling) and the score memory plus cell-calculator datapath.

Parameters:
- LEN_A, 4, length of sequence A (matrix rows 1..LEN_A)
- LEN_B, 4, length of sequence B (matrix columns 1..LEN_B)
- IDX_W, 3, index width; must hold max(LEN_A, LEN_B)
- ADDR_W, 5, memory address width; must hold (LEN_A+1)*(LEN_B+1)-1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin filling; sampled in IDLE only
- calc_done  in  1  cell result valid; sampled in WAIT only
- rd_en  out  1  memory read strobe; read data is valid one cycle later
- rd_addr  out  ADDR_W  read address
- ld_diag  out  1  capture read data as diag operand
- ld_up  out  1  capture read data as up operand
- ld_left  out  1  capture read data as left operand
- calc_start  out  1  one-cycle start pulse to the calculator
- we  out  1  memory write strobe for the calculator result
- wr_addr  out  ADDR_W  write address
- i  out  IDX_W  current row
- j  out  IDX_W  current column
- busy  out  1  high in every state except IDLE
- end_filling  out  1  one-cycle pulse when the last cell has been written

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - rst is synchronous and active-high.
  - On rst: state=IDLE, i=0, j=0, and every strobe, busy, end_filling, rd_addr and wr_addr are 0.
  - rst mid-operation aborts immediately with no final write.
- Addressing: addr(r,c) = r*(LEN_B+1)+c, computed at ADDR_W bits with no truncation (guaranteed by the parameter rule).
- States: IDLE, RD_DIAG, RD_UP, RD_LEFT, CALC, WAIT, WRITE, DONE.
- IDLE:
  - start=1 -> load i=1, j=1, go to RD_DIAG.
  - Otherwise stay.
- RD_DIAG: rd_en=1, rd_addr=addr(i-1,j-1); -> RD_UP.
- RD_UP: rd_en=1, rd_addr=addr(i-1,j), ld_diag=1; -> RD_LEFT.
- RD_LEFT: rd_en=1, rd_addr=addr(i,j-1), ld_up=1; -> CALC.
- CALC: ld_left=1, calc_start=1; -> WAIT.
- WAIT:
  - calc_done=1 -> WRITE.
  - Otherwise stay (unbounded, no timeout).
- WRITE:
  - we=1, wr_addr=addr(i,j).
  - If i==LEN_A and j==LEN_B -> DONE.
  - Else if j==LEN_B -> i=i+1, j=1, go to RD_DIAG.
  - Else j=j+1, go to RD_DIAG.
- DONE: end_filling=1 for exactly one cycle; -> IDLE. i and j hold their last values.
- Output timing:
  - All strobes are registered-state decodes (Moore), so each is high for exactly one cycle per cell.
  - Minimum cell period is 6 cycles, when calc_done arrives in the first WAIT cycle.
- Ignored inputs:
  - start is ignored while busy=1.
  - calc_done is ignored outside WAIT.
- Degenerate size: LEN_A=LEN_B=1 gives a single cell, then DONE.

Optional Feature:
- Macro: NW_FILL_LEFT_FWD_EN
- Defined:
  - For cells with j>1, RD_LEFT is skipped; RD_UP goes directly to CALC.
  - In CALC, the output left_fwd (1 bit, present only under the macro) pulses instead of ld_left; the calculator reuses its previous result as the left operand.
  - ld_up is then asserted in CALC together with left_fwd.
  - Cell period is 5 cycles minimum for j>1; j==1 cells are unchanged.
- Undefined: every cell performs all three reads as described above.

Decomposition:
- Package nw_pkg holds:
  - state localparams (3-bit encoding);
  - the addr() function;
  - shared LEN_A/LEN_B defaults used by the top FSM and the memory.
- Sub-module nw_idx_counter:
  - row/column counter with load-to-(1,1), increment, and wrap of j to 1 with i increment;
  - outputs last_cell = (i==LEN_A && j==LEN_B).

Test Plan:
- Reset then start=1 for 1 cycle, calc_done tied 1 -> first cell reads addr 0, 1, 5 on consecutive cycles; we with wr_addr=6 in cycle 6 after leaving IDLE.
- Full run, calc_done=1 -> 16 writes at addresses 6,7,8,9,11,…,24, then end_filling pulses once, exactly 97 cycles after leaving IDLE, and busy drops the next cycle.
- calc_done held 0 for 10 cycles at cell (2,3) -> the FSM stays in WAIT and no strobes fire; write to addr 13 occurs 1 cycle after calc_done rises.
- start pulsed mid-run and calc_done pulsed during RD_UP -> no effect: sequence and address trace identical to the baseline run.
- rst asserted in WAIT at cell (3,2) -> next cycle IDLE, all outputs 0; a new start restarts at (1,1) with read addr 0.
- NW_FILL_LEFT_FWD_EN defined, calc_done=1 -> cell (1,2) issues only reads 1 and 2 and pulses left_fwd; full run takes 4*6 + 12*5 + 1 = 85 cycles to end_filling.

Source files
------------

// File: rtl/nw_fill_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nw_pkg
// Purpose  : Shared definitions for the Needleman-Wunsch fill sequencer:
//            default matrix dimensions, 3-bit FSM state encoding and the
//            row-major score-memory address helper.
// Revision : 1.0  initial release
// ============================================================================
package nw_pkg;

    // Default sequence lengths shared by the fill FSM and the score memory
    localparam int c_LEN_A = 4;
    localparam int c_LEN_B = 4;

    // Fill FSM state encoding
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_DIAG = 3'd1;
    localparam logic [2:0] c_RD_UP   = 3'd2;
    localparam logic [2:0] c_RD_LEFT = 3'd3;
    localparam logic [2:0] c_CALC    = 3'd4;
    localparam logic [2:0] c_WAIT    = 3'd5;
    localparam logic [2:0] c_WRITE   = 3'd6;
    localparam logic [2:0] c_DONE    = 3'd7;

    // Row-major address of cell (r,c) in a matrix with len_b+1 columns
    function automatic int addr(input int r, input int c, input int len_b);
        return r * (len_b + 1) + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nw_fill_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : nw_fill_sequencer_if
// Purpose  : Bundle between the fill sequencer and its environment
//            (control FSM, score memory, cell calculator).
//   master : sequencer side - drives read/write strobes, operand loads,
//            calc_start, i/j, busy, end_filling (and left_fwd when
//            NW_FILL_LEFT_FWD_EN is defined); receives start, calc_done.
//   slave  : environment side, mirror of master.
// Revision : 1.0  initial release
// ============================================================================
interface nw_fill_sequencer_if #(
    parameter int IDX_W  = 3,
    parameter int ADDR_W = 5
);
    logic              start;
    logic              calc_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              ld_diag;
    logic              ld_up;
    logic              ld_left;
    logic              calc_start;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [IDX_W-1:0]  i;
    logic [IDX_W-1:0]  j;
    logic              busy;
    logic              end_filling;
`ifdef NW_FILL_LEFT_FWD_EN
    logic              left_fwd;
`endif

    modport master (
        input  start, calc_done,
        output rd_en, rd_addr, ld_diag, ld_up, ld_left, calc_start,
               we, wr_addr, i, j, busy, end_filling
`ifdef NW_FILL_LEFT_FWD_EN
        , output left_fwd
`endif
    );

    modport slave (
        output start, calc_done,
        input  rd_en, rd_addr, ld_diag, ld_up, ld_left, calc_start,
               we, wr_addr, i, j, busy, end_filling
`ifdef NW_FILL_LEFT_FWD_EN
        , input left_fwd
`endif
    );

endinterface
`default_nettype wire

// File: rtl/nw_fill_sequencer_idx_counter.sv
`default_nettype none
// ============================================================================
// Module   : nw_idx_counter
// Purpose  : Row/column cell counter for the matrix fill.
//   clk, rst  : clock, synchronous active-high reset (i=j=0)
//   load      : set (i,j) to (1,1)
//   inc       : advance row-major; j wraps to 1 with i incremented
//   i, j      : current cell
//   last_cell : (i==LEN_A && j==LEN_B)
// Revision : 1.0  initial release
// ============================================================================
module nw_idx_counter #(
    parameter int LEN_A = 4,
    parameter int LEN_B = 4,
    parameter int IDX_W = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             inc,
    output logic [IDX_W-1:0]      i,
    output logic [IDX_W-1:0]      j,
    output logic                  last_cell
);

    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic             w_row_end;

    assign w_row_end = (r_j == IDX_W'(LEN_B));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i <= '0;
            r_j <= '0;
        end else if (load) begin
            r_i <= IDX_W'(1);
            r_j <= IDX_W'(1);
        end else if (inc) begin
            if (w_row_end) begin
                r_i <= r_i + IDX_W'(1);
                r_j <= IDX_W'(1);
            end else begin
                r_j <= r_j + IDX_W'(1);
            end
        end
    end

    assign i         = r_i;
    assign j         = r_j;
    assign last_cell = (r_i == IDX_W'(LEN_A)) && w_row_end;

endmodule
`default_nettype wire

// File: rtl/nw_fill_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nw_fill_sequencer
// Purpose  : Walks the Needleman-Wunsch score matrix from (1,1) to
//            (LEN_A,LEN_B) row-major. Per cell: read diag/up/left
//            neighbours, load operands, start the calculator, wait for
//            calc_done, write the result back. end_filling pulses once
//            after the last write.
// Ports    : clk, rst (synchronous, active-high)
//            bus (nw_fill_sequencer_if.master): start, calc_done in;
//            rd_en/rd_addr, ld_diag/ld_up/ld_left, calc_start, we/wr_addr,
//            i, j, busy, end_filling out.
// Option   : NW_FILL_LEFT_FWD_EN - for j>1 cells the left read is skipped
//            and left_fwd tells the calculator to reuse its last result.
// Revision : 1.0  initial release
// ============================================================================
module nw_fill_sequencer
    import nw_pkg::*;
#(
    parameter int LEN_A  = c_LEN_A,
    parameter int LEN_B  = c_LEN_B,
    parameter int IDX_W  = 3,
    parameter int ADDR_W = 5
) (
    input  wire logic            clk,
    input  wire logic            rst,
    nw_fill_sequencer_if.master  bus
);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             w_load;
    logic             w_inc;
    logic             w_last;
    logic [IDX_W-1:0] w_i;
    logic [IDX_W-1:0] w_j;

    function automatic logic [ADDR_W-1:0] cell_addr(input int r, input int c);
        return ADDR_W'(addr(r, c, LEN_B));
    endfunction

    nw_idx_counter #(
        .LEN_A (LEN_A),
        .LEN_B (LEN_B),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .inc       (w_inc),
        .i         (w_i),
        .j         (w_j),
        .last_cell (w_last)
    );

`ifdef NW_FILL_LEFT_FWD_EN
    // Left neighbour of a j>1 cell is the result just produced
    logic w_fwd_cell;
    assign w_fwd_cell = (w_j != IDX_W'(1));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and counter control
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_next = c_RD_DIAG;
                    w_load = 1'b1;
                end
            end
            c_RD_DIAG: w_next = c_RD_UP;
            c_RD_UP: begin
`ifdef NW_FILL_LEFT_FWD_EN
                w_next = w_fwd_cell ? c_CALC : c_RD_LEFT;
`else
                w_next = c_RD_LEFT;
`endif
            end
            c_RD_LEFT: w_next = c_CALC;
            c_CALC:    w_next = c_WAIT;
            c_WAIT: begin
                if (bus.calc_done) w_next = c_WRITE;
            end
            c_WRITE: begin
                if (w_last) begin
                    w_next = c_DONE;
                end else begin
                    w_next = c_RD_DIAG;
                    w_inc  = 1'b1;
                end
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Moore output decode; read data lags rd_en by one cycle, so each
    // ld_* strobe sits in the state after the matching read
    always_comb begin
        bus.rd_en       = 1'b0;
        bus.rd_addr     = '0;
        bus.ld_diag     = 1'b0;
        bus.ld_up       = 1'b0;
        bus.ld_left     = 1'b0;
        bus.calc_start  = 1'b0;
        bus.we          = 1'b0;
        bus.wr_addr     = '0;
        bus.end_filling = 1'b0;
`ifdef NW_FILL_LEFT_FWD_EN
        bus.left_fwd    = 1'b0;
`endif
        case (r_state)
            c_RD_DIAG: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = cell_addr(int'(w_i) - 1, int'(w_j) - 1);
            end
            c_RD_UP: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = cell_addr(int'(w_i) - 1, int'(w_j));
                bus.ld_diag = 1'b1;
            end
            c_RD_LEFT: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = cell_addr(int'(w_i), int'(w_j) - 1);
                bus.ld_up   = 1'b1;
            end
            c_CALC: begin
                bus.calc_start = 1'b1;
`ifdef NW_FILL_LEFT_FWD_EN
                if (w_fwd_cell) begin
                    bus.ld_up    = 1'b1;
                    bus.left_fwd = 1'b1;
                end else begin
                    bus.ld_left  = 1'b1;
                end
`else
                bus.ld_left    = 1'b1;
`endif
            end
            c_WRITE: begin
                bus.we      = 1'b1;
                bus.wr_addr = cell_addr(int'(w_i), int'(w_j));
            end
            c_DONE: bus.end_filling = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy = (r_state != c_IDLE);
    assign bus.i    = w_i;
    assign bus.j    = w_j;

endmodule
`default_nettype wire

// File: tb/tb_nw_fill_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nw_fill_sequencer
// Purpose  : Self-checking bench for nw_fill_sequencer. A cell-level model
//            (nested row/column loops) predicts every output each cycle;
//            directed runs pin timing, address traces, stalls, ignored
//            inputs and mid-run reset. Handles NW_FILL_LEFT_FWD_EN builds.
// Revision : 1.0  initial release
// ============================================================================
module tb_nw_fill_sequencer;

    localparam int LEN_A  = 4;
    localparam int LEN_B  = 4;
    localparam int IDX_W  = 3;
    localparam int ADDR_W = 5;
    localparam int VW     = 9 + 2 * ADDR_W + 2 * IDX_W;
    localparam int MAXR   = 200;
`ifdef NW_FILL_LEFT_FWD_EN
    localparam bit FWD    = 1'b1;
`else
    localparam bit FWD    = 1'b0;
`endif
    // Cycles from leaving IDLE to end_filling: 16*6+1, or 4*6+12*5+1
    localparam int EF_REL = FWD ? 85 : 97;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stim_start = 1'b0;
    logic stim_cd    = 1'b0;
    always #5 clk = ~clk;

    nw_fill_sequencer_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

    nw_fill_sequencer #(
        .LEN_A (LEN_A), .LEN_B (LEN_B), .IDX_W (IDX_W), .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.start     = stim_start;
    assign bus.calc_done = stim_cd;

    logic w_lf;
`ifdef NW_FILL_LEFT_FWD_EN
    assign w_lf = bus.left_fwd;
`else
    assign w_lf = 1'b0;
`endif

    function automatic logic [VW-1:0] pack(
        input logic busy, ef, rd, input logic [ADDR_W-1:0] rda,
        input logic ldd, ldu, ldl, cs, we, input logic [ADDR_W-1:0] wra,
        input logic [IDX_W-1:0] ii, jj, input logic lf);
        return {busy, ef, rd, rda, ldd, ldu, ldl, cs, we, wra, ii, jj, lf};
    endfunction

    logic [VW-1:0] w_act;
    assign w_act = pack(bus.busy, bus.end_filling, bus.rd_en, bus.rd_addr,
                        bus.ld_diag, bus.ld_up, bus.ld_left, bus.calc_start,
                        bus.we, bus.wr_addr, bus.i, bus.j, w_lf);

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int rel_now  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- schedule arithmetic from the cell rules ----------------
    function automatic int maddr(input int r, input int c);
        return r * (LEN_B + 1) + c;
    endfunction
    function automatic int period(input int c);
        return (FWD && c > 1) ? 5 : 6;
    endfunction
    function automatic int cell_start(input int r, input int c);
        int s = 1;
        for (int k = 0; k < (r - 1) * LEN_B + (c - 1); k++) s += period(k % LEN_B + 1);
        return s;
    endfunction
    function automatic int wait_rel(input int r, input int c);
        return cell_start(r, c) + period(c) - 2;
    endfunction
    function automatic bit in_sched(input int rel);
        for (int r = 1; r <= LEN_A; r++)
            for (int c = 1; c <= LEN_B; c++)
                if (rel == wait_rel(r, c) || rel == cell_start(r, c) + 1) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- behavioural model ----------------
    logic [VW-1:0] exp_v = '0;
    int  mi = 0, mj = 0;
    bit  m_abort, m_start, m_done;

    task automatic set_exp(input bit busy, ef, rd, input int rda,
                           input bit ldd, ldu, ldl, cs, we, input int wra, input bit lf);
        exp_v = pack(busy, ef, rd, ADDR_W'(rda), ldd, ldu, ldl, cs, we,
                     ADDR_W'(wra), IDX_W'(mi), IDX_W'(mj), lf);
    endtask

    task automatic mstep();
        @(posedge clk);
        m_abort = rst;
        m_start = stim_start;
        m_done  = stim_cd;
    endtask

    task automatic m_cell(input int r, input int c);
        mi = r; mj = c;
        set_exp(1, 0, 1, maddr(r - 1, c - 1), 0, 0, 0, 0, 0, 0, 0);
        mstep(); if (m_abort) return;
        set_exp(1, 0, 1, maddr(r - 1, c), 1, 0, 0, 0, 0, 0, 0);
        mstep(); if (m_abort) return;
        if (FWD && c > 1) begin
            set_exp(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
        end else begin
            set_exp(1, 0, 1, maddr(r, c - 1), 0, 1, 0, 0, 0, 0, 0);
            mstep(); if (m_abort) return;
            set_exp(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        end
        mstep(); if (m_abort) return;
        set_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do begin
            mstep(); if (m_abort) return;
        end while (!m_done);
        set_exp(1, 0, 0, 0, 0, 0, 0, 0, 1, maddr(r, c), 0);
        mstep();
    endtask

    initial begin
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        forever begin
            mstep();
            if (m_abort) begin
                mi = 0; mj = 0;
                set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end else if (m_start) begin
                for (int r = 1; r <= LEN_A; r++)
                    for (int c = 1; c <= LEN_B; c++)
                        if (!m_abort) m_cell(r, c);
                if (!m_abort) begin
                    set_exp(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    mstep();
                end
                if (m_abort) begin mi = 0; mj = 0; end
                set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
        end
    end

    // ---------------- per-cycle compare + trace capture ----------------
    logic [VW-1:0]     s_vec   [256];
    logic [VW-1:0]     base_vec[256];
    logic              s_rd    [256];
    logic [ADDR_W-1:0] s_rda   [256];
    logic              s_we    [256];
    logic [ADDR_W-1:0] s_wra   [256];
    logic              s_ef    [256];
    logic              s_busy  [256];
    logic              s_strb  [256];
    logic              s_lf    [256];

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checks++;
            if (w_act !== exp_v) begin
                failures++;
                $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, w_act, exp_v);
            end
        end
        if (rel_now > 0 && rel_now < 256) begin
            s_vec[rel_now]  = w_act;
            s_rd[rel_now]   = bus.rd_en;
            s_rda[rel_now]  = bus.rd_addr;
            s_we[rel_now]   = bus.we;
            s_wra[rel_now]  = bus.wr_addr;
            s_ef[rel_now]   = bus.end_filling;
            s_busy[rel_now] = bus.busy;
            s_lf[rel_now]   = w_lf;
            s_strb[rel_now] = bus.rd_en | bus.ld_diag | bus.ld_up | bus.ld_left
                            | bus.calc_start | bus.we | w_lf;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    // One fill run. stall_at: first of 10 calc_done-low cycles (0=none);
    // disturb: calc_done only in WAIT/RD_UP cycles plus a mid-run start;
    // rst_at: cycle in which rst is raised (0=none).
    task automatic run(input int stall_at, input bit disturb, input int rst_at, output int ef_rel);
        for (int k = 0; k < 256; k++) begin
            s_vec[k] = '0; s_rd[k] = 1'b0; s_rda[k] = '0; s_we[k] = 1'b0; s_wra[k] = '0;
            s_ef[k] = 1'b0; s_busy[k] = 1'b0; s_strb[k] = 1'b0; s_lf[k] = 1'b0;
        end
        ef_rel = -1;
        stim_cd = !disturb;
        stim_start = 1'b1;
        tick();
        stim_start = 1'b0;
        for (int rel = 1; rel <= MAXR; rel++) begin
            rel_now = rel;
            if (disturb) begin
                stim_cd    = in_sched(rel);
                stim_start = (rel >= 20 && rel <= 22);
            end else begin
                stim_cd = !(stall_at != 0 && rel >= stall_at && rel < stall_at + 10);
            end
            rst = (rel == rst_at);
            @(negedge clk);
            if (bus.end_filling && ef_rel < 0) ef_rel = rel;
            tick();
            if (rel == rst_at) begin
                rst = 1'b0;
                rel_now = 0;
                @(negedge clk);
                check("rst_abort_outputs", int'(w_act), 0);
                break;
            end
            if (ef_rel > 0 && rel >= ef_rel + 2) break;
        end
        rel_now = 0;
        stim_start = 1'b0;
        stim_cd = 1'b1;
        if (rst_at == 0 && ef_rel < 0) begin
            checks++; failures++;
            $display("FAIL end_filling_timeout actual=none required=pulse");
        end
    endtask

    int exp_wr[16] = '{6, 7, 8, 9, 11, 12, 13, 14, 16, 17, 18, 19, 21, 22, 23, 24};

    initial begin
        int ef, n, fr, w;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("reset_outputs", int'(w_act), 0);
        rst = 1'b0;
        stim_cd = 1'b1;
        tick(); tick();

        // Baseline full run, calc_done tied high
        run(0, 1'b0, 0, ef);
        check("ef_rel", ef, EF_REL);
        check("rd1_addr", int'(s_rda[1]), 0);
        check("rd2_addr", int'(s_rda[2]), 1);
        check("rd3_addr", int'(s_rda[3]), 5);
        check("rd123_en", int'(s_rd[1]) + int'(s_rd[2]) + int'(s_rd[3]), 3);
        fr = 0;
        for (int r = MAXR; r >= 1; r--) if (s_we[r]) fr = r;
        check("first_we_rel", fr, 6);
        n = 0;
        for (int r = 1; r <= MAXR; r++) begin
            if (s_we[r]) begin
                if (n < 16) check("wr_addr_seq", int'(s_wra[r]), exp_wr[n]);
                n++;
            end
        end
        check("write_count", n, 16);
        n = 0;
        for (int r = 1; r <= MAXR; r++) n += int'(s_ef[r]);
        check("ef_pulse_count", n, 1);
        if (ef > 0 && ef < 250) begin
            check("busy_at_ef", int'(s_busy[ef]), 1);
            check("busy_after_ef", int'(s_busy[ef + 1]), 0);
        end
`ifdef NW_FILL_LEFT_FWD_EN
        n = 0;
        for (int r = 7; r <= 11; r++) n += int'(s_rd[r]);
        check("fwd_cell12_reads", n, 2);
        check("fwd_cell12_rd_a", int'(s_rda[7]), 1);
        check("fwd_cell12_rd_b", int'(s_rda[8]), 2);
        n = 0;
        for (int r = 7; r <= 11; r++) n += int'(s_lf[r]);
        check("fwd_cell12_left_fwd", n, 1);
`endif
        for (int k = 0; k < 256; k++) base_vec[k] = s_vec[k];

        // Stall at cell (2,3): 10 cycles of calc_done low in WAIT
        w = wait_rel(2, 3);
        run(w, 1'b0, 0, ef);
        check("stall_ef_rel", ef, EF_REL + 10);
        n = 0;
        for (int r = w; r <= w + 10; r++) n += int'(s_strb[r]);
        check("stall_no_strobes", n, 0);
        n = 0;
        for (int r = w; r <= w + 10; r++) n += int'(s_busy[r]);
        check("stall_busy", n, 11);
        check("stall_we", int'(s_we[w + 11]), 1);
        check("stall_wr_addr", int'(s_wra[w + 11]), 13);

        // Ignored inputs: start mid-run, calc_done in RD_UP
        run(0, 1'b1, 0, ef);
        check("disturb_ef_rel", ef, EF_REL);
        n = 0;
        for (int r = 1; r <= EF_REL + 1; r++) if (s_vec[r] !== base_vec[r]) n++;
        check("disturb_trace_diffs", n, 0);

        // Reset in WAIT at cell (3,2), then a clean restart
        run(0, 1'b0, wait_rel(3, 2), ef);
        run(0, 1'b0, 0, ef);
        check("restart_rd_addr", int'(s_rda[1]), 0);
        check("restart_rd_en", int'(s_rd[1]), 1);
        check("restart_ij", int'(s_vec[1][2*IDX_W:1]), 9);
        check("restart_ef_rel", ef, EF_REL);

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
